// File: rtl/pipelined_mac_if.sv
// pipelined_mac_if: valid/ready stream bundle for the pipelined multiply-accumulate block.
`default_nettype none

interface pipelined_mac_if #(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16,
  parameter int ACC_GUARD    = 8
);
  localparam int OUT_W = DATA_WIDTH_1 + DATA_WIDTH_2 + ACC_GUARD;

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [DATA_WIDTH_1-1:0] data1_i;
  logic [DATA_WIDTH_2-1:0] data2_i;
  logic                    signed_i;
  logic                    acc_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [OUT_W-1:0]        data_o;

  modport master (
    output in_valid_i, data1_i, data2_i, signed_i, acc_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );

  modport slave (
    input  in_valid_i, data1_i, data2_i, signed_i, acc_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );
endinterface

`default_nettype wire

// File: rtl/pipelined_mac.sv
// pipelined_mac: PIPE_STAGES-deep signed/unsigned multiplier with optional accumulate,
// valid/ready handshake and global-stall backpressure.
`default_nettype none

module pipelined_mac #(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16,
  parameter int PIPE_STAGES  = 3,
  parameter int ACC_GUARD    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_mac_if.slave   bus
);
  localparam int PROD_W = DATA_WIDTH_1 + DATA_WIDTH_2;
  localparam int OUT_W  = PROD_W + ACC_GUARD;
  localparam int NS     = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  logic              advance;
  logic [PROD_W-1:0] op1_ext;
  logic [PROD_W-1:0] op2_ext;
  logic [PROD_W-1:0] product;
  logic              last_valid;
  logic              last_acc;
  logic              last_sgn;
  logic [PROD_W-1:0] last_prod;
  logic [OUT_W-1:0]  prod_ext;
  logic [OUT_W-1:0]  acc_q;
  logic              out_valid_q;

  assign advance        = ~out_valid_q | bus.out_ready_i;
  assign bus.in_ready_o = advance;

  // Extending both operands to the full product width first makes the
  // truncated product correct for both two's-complement and unsigned inputs.
  always_comb begin
    op1_ext = bus.signed_i ? {{DATA_WIDTH_2{bus.data1_i[DATA_WIDTH_1-1]}}, bus.data1_i}
                           : {{DATA_WIDTH_2{1'b0}}, bus.data1_i};
    op2_ext = bus.signed_i ? {{DATA_WIDTH_1{bus.data2_i[DATA_WIDTH_2-1]}}, bus.data2_i}
                           : {{DATA_WIDTH_1{1'b0}}, bus.data2_i};
    product = op1_ext * op2_ext;
  end

  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign last_valid = bus.in_valid_i;
      assign last_prod  = product;
      assign last_acc   = bus.acc_i;
      assign last_sgn   = bus.signed_i;
    end else begin : g_multi
      logic [NS-1:0]     stg_valid;
      logic [NS-1:0]     stg_acc;
      logic [NS-1:0]     stg_sgn;
      logic [PROD_W-1:0] stg_prod [NS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_valid <= '0;
          stg_acc   <= '0;
          stg_sgn   <= '0;
          for (int i = 0; i < NS; i++) begin
            stg_prod[i] <= '0;
          end
        end else if (advance) begin
          stg_valid[0] <= bus.in_valid_i;
          stg_acc[0]   <= bus.acc_i;
          stg_sgn[0]   <= bus.signed_i;
          stg_prod[0]  <= product;
          for (int i = 1; i < NS; i++) begin
            stg_valid[i] <= stg_valid[i-1];
            stg_acc[i]   <= stg_acc[i-1];
            stg_sgn[i]   <= stg_sgn[i-1];
            stg_prod[i]  <= stg_prod[i-1];
          end
        end
      end

      assign last_valid = stg_valid[NS-1];
      assign last_prod  = stg_prod[NS-1];
      assign last_acc   = stg_acc[NS-1];
      assign last_sgn   = stg_sgn[NS-1];
    end
  endgenerate

  assign prod_ext = last_sgn ? {{ACC_GUARD{last_prod[PROD_W-1]}}, last_prod}
                             : {{ACC_GUARD{1'b0}}, last_prod};

  // The output register doubles as the accumulator, so consecutive
  // accumulate beats always see the previous result with no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else if (advance) begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        acc_q <= last_acc ? (acc_q + prod_ext) : prod_ext;
      end
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.data_o      = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_mac.sv
// tb_pipelined_mac: directed vectors with a queue scoreboard and an independent output monitor.
`default_nettype none

module tb_pipelined_mac;
  localparam int W1 = 16;
  localparam int W2 = 16;
  localparam int P  = 3;
  localparam int G  = 8;
  localparam int OW = W1 + W2 + G;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_mac_if #(.DATA_WIDTH_1(W1), .DATA_WIDTH_2(W2), .ACC_GUARD(G)) bus ();

  pipelined_mac #(
    .DATA_WIDTH_1(W1),
    .DATA_WIDTH_2(W2),
    .PIPE_STAGES (P),
    .ACC_GUARD   (G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int            total = 0;
  int            bad = 0;
  int            stall_cycles = 0;
  logic [OW-1:0] expq[$];
  logic [OW-1:0] last_out = '0;
  logic          stalled_prev = 1'b0;
  logic [OW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops and compares on every output transfer, checks stall behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid_o && !bus.out_ready_i) begin
          stall_cycles++;
          check("stall_in_ready", OW'(bus.in_ready_o), OW'(0));
          if (stalled_prev) check("stall_hold", bus.data_o, stall_data);
          stalled_prev = 1'b1;
          stall_data   = bus.data_o;
        end else begin
          stalled_prev = 1'b0;
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h expected none", bus.data_o);
          end else begin
            check("result", bus.data_o, expq.pop_front());
          end
          last_out = bus.data_o;
        end
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic send(input logic [W1-1:0] a, input logic [W2-1:0] b,
                      input logic sgn, input logic ac, input logic [OW-1:0] exp_val);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    #1;
    bus.in_valid_i = 1'b1;
    bus.data1_i    = a;
    bus.data2_i    = b;
    bus.signed_i   = sgn;
    bus.acc_i      = ac;
    do begin
      @(negedge clk);
      ok = bus.in_ready_o;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      expq.push_back(exp_val);
    end
  endtask

  task automatic idle();
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] sum;
    bus.in_valid_i  = 1'b0;
    bus.data1_i     = '0;
    bus.data2_i     = '0;
    bus.signed_i    = 1'b0;
    bus.acc_i       = 1'b0;
    bus.out_ready_i = 1'b1;

    #12;
    check("reset_out_valid", OW'(bus.out_valid_o), OW'(0));
    check("reset_data", bus.data_o, OW'(0));
    check("reset_in_ready", OW'(bus.in_ready_o), OW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Unsigned max product and latency
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'h00FFFE0001);
    idle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("latency", OW'(bus.out_valid_o), OW'(i == 3));
    end
    drain();

    // Signed vs unsigned interpretation
    send(16'hFFFD, 16'h0005, 1'b1, 1'b0, 40'hFFFFFFFFF1);
    send(16'hFFFD, 16'h0005, 1'b0, 1'b0, 40'h000004FFF1);
    idle();
    drain();

    // Back-to-back accumulate chain, then restart
    send(16'd2, 16'd3, 1'b0, 1'b0, 40'd6);
    send(16'd4, 16'd5, 1'b0, 1'b1, 40'd26);
    send(16'd6, 16'd7, 1'b0, 1'b1, 40'd68);
    send(16'd1, 16'd1, 1'b0, 1'b0, 40'd1);
    idle();
    drain();

    // Backpressure: 4-cycle consumer stall mid-stream
    stall_cycles = 0;
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          send(W1'(k), 16'd10, 1'b0, 1'b0, OW'(10 * k));
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
      end
    join
    drain();
    check("stall_cycles", OW'(stall_cycles), OW'(4));

    // Wrap: 257 accumulations of 0xFFFF*0xFFFF
    sum = '0;
    for (int k = 0; k < 257; k++) begin
      sum = sum + 40'h00FFFE0001;
      send(16'hFFFF, 16'hFFFF, 1'b0, (k != 0), sum);
    end
    idle();
    drain();
    check("wrap_final", last_out, 40'h00FDFE0101);

    // Reset with beats in flight
    send(16'd3, 16'd3, 1'b0, 1'b0, 40'd9);
    send(16'd4, 16'd4, 1'b0, 1'b1, 40'd25);
    send(16'd5, 16'd5, 1'b0, 1'b1, 40'd50);
    #2;
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", OW'(bus.out_valid_o), OW'(0));
    check("midreset_data", bus.data_o, OW'(0));
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    send(16'd2, 16'd2, 1'b0, 1'b1, 40'd4);
    idle();
    drain();
    check("post_reset_acc", last_out, 40'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_mac.md
Name: pipelined_mac

Overview:
- Parametrised successor to the team's single-cycle registered multiplier.
- Pipelined multiplier with configurable latency, per-beat signed/unsigned mode and an optional accumulate mode (multiply-accumulate).
- Uses a valid/ready handshake with full backpressure.
- Sits in DSP datapaths (filters, correlators, power estimators) between a streaming source and a consumer that may stall.

Parameters:
- DATA_WIDTH_1, 16, width of operand 1 (multiplier).
- DATA_WIDTH_2, 16, width of operand 2 (multiplicand).
- PIPE_STAGES, 3, number of register stages from input acceptance to output; legal range 1..8.
- ACC_GUARD, 8, extra accumulator bits above the full product width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- data1_i  input  DATA_WIDTH_1  operand 1.
- data2_i  input  DATA_WIDTH_2  operand 2.
- signed_i  input  1  1 = both operands two's complement; 0 = both unsigned.
- acc_i  input  1  1 = add product to accumulator; 0 = load product (restart).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- data_o  output  OUT_W  result, OUT_W = DATA_WIDTH_1+DATA_WIDTH_2+ACC_GUARD.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - All stage valid bits, out_valid_o, data_o and the accumulator clear to 0 immediately on rst_n low.
  - in_ready_o is 1 out of reset.
  - Reset mid-operation discards all in-flight beats and the accumulated value; no partial result emerges.
- Handshake:
  - A beat transfers on input when in_valid_i & in_ready_o.
  - A beat transfers on output when out_valid_o & out_ready_i.
  - Data, signed_i and acc_i are sampled only on input transfer.
- Global advance: advance = ~out_valid_o | out_ready_i; in_ready_o = advance (combinational).
  - When advance = 1, every stage (data plus valid bit) shifts one position.
  - When advance = 0, all stages hold.
  - A bubble (no input transfer) propagates as valid = 0.
  - Pipeline bubbles are squeezed out only by advancing; the block does no bubble collapsing.
- Latency:
  - Exactly PIPE_STAGES cycles from input transfer to out_valid_o, when never stalled.
  - Sustained throughput is 1 beat/cycle when out_ready_i = 1.
- Arithmetic:
  - Stage 1 forms the full (DATA_WIDTH_1+DATA_WIDTH_2)-bit product, with operands sign- or zero-extended per signed_i.
  - Stages 2..PIPE_STAGES delay the product together with acc and signed flags.
  - Final stage: the product is extended to OUT_W (sign-extended if signed, else zero-extended).
  - If acc = 0, data_o <= product and the accumulator <= product.
  - If acc = 1, data_o <= accumulator + product and the accumulator <= same value.
  - The accumulator and data_o are the same register; it updates only when a valid beat enters the output stage.
  - Overflow wraps modulo 2^OUT_W; no saturation, no flag.
- Back-to-back accumulate beats must chain correctly: each beat uses the accumulator value left by the previous beat, with no hazard at any PIPE_STAGES.
- acc_i = 1 on the first beat after reset accumulates onto 0.
- Mixing signed and unsigned beats in one accumulation is legal; the extension is per beat.
- data_o holds its value while out_valid_o = 1 and out_ready_i = 0, and also after the output transfer until the next result loads.
- PIPE_STAGES = 1: the product and accumulate happen in the single output stage; the behaviour rules above still hold.

Test Plan:
- Unsigned 16x16, acc = 0, out_ready_i = 1: 0xFFFF*0xFFFF -> data_o = 0x00_FFFE0001 exactly 3 cycles after acceptance, out_valid_o for 1 cycle.
- Signed, acc = 0: -3 * 5 (0xFFFD, 0x0005) -> data_o = all-ones prefix ...FFF1 (-15 in 40 bits); same operands with signed_i = 0 -> 0x0004_FFF1.
- Accumulate stream, back-to-back: beats (2,3,acc=0),(4,5,acc=1),(6,7,acc=1) -> outputs 6, 26, 68 on consecutive cycles; a following (1,1,acc=0) -> 1.
- Backpressure: 5 beats streaming, out_ready_i low for 4 cycles mid-stream -> in_ready_o low during the stall, data_o stable, no beat lost or duplicated, order preserved.
- Wrap: accumulate 0xFFFF*0xFFFF unsigned 257 times -> data_o equals the 257x product modulo 2^40.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid_o = 0 and data_o = 0 at once; a later acc = 1 beat (2,2) -> 4.
